hit_scan_ctrl: RTL

Sequencer for the seed-hit datapath (22-bit w-mer comparator bank plus 2-bit database shift register). It takes one 512-bit query and a run of 512-bit database words from DDR, and drives `query`/`queryValid`/`dataBase`/`dataBaseValid`/`load`/`shift`/`stop` into the hit datapath. It paces shifts so that every window is evaluated once and attributed exactly. Each hit is emitted as a record on a valid/ready stream.

---
 rtl/hit_scan_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hit_scan_ctrl.sv
// hit_scan_ctrl: paces query/database loads and window shifts
// into the seed-hit datapath and streams out one record per hit.
module hit_scan_ctrl #(
   parameter int SHIFTS_PER_WORD = 245,
   parameter int HIT_LAT         = 2,
   parameter int WIDX_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDX_W-1:0] numWords,
   input  logic [511:0]      queryIn,
   input  logic              queryInValid,
   output logic              queryInReady,
   input  logic [511:0]      ddrData,
   input  logic              ddrValid,
   output logic              ddrReady,
   output logic [511:0]      query,
   output logic              queryValid,
   output logic [511:0]      dataBase,
   output logic              dataBaseValid,
   output logic              load,
   output logic              shift,
   output logic              stop,
   input  logic              hit,
   input  logic [8:0]        locationQ,
   output logic              hitValid,
   input  logic              hitReady,
   output logic [WIDX_W-1:0] hitWordIdx,
   output logic [8:0]        hitShift,
   output logic [8:0]        hitQLoc,
   output logic              busy,
   output logic              done
);

   localparam int WW = $clog2(HIT_LAT + 2);
   localparam logic [WW-1:0] LAT    = WW'(HIT_LAT);
   localparam logic [WW-1:0] LAT_M1 = WW'(HIT_LAT - 1);
   localparam logic [WW-1:0] W_ONE  = WW'(1);
   localparam logic [8:0]    SPW    = 9'(SHIFTS_PER_WORD);
   localparam logic [WIDX_W-1:0] I_ONE = WIDX_W'(1);

   typedef enum logic [3:0] {
      IDLE, QLOAD, FETCH, LOAD, EVAL,
      SHIFT, REPORT, STOP, DONE
   } state_t;

   state_t state, state_nxt;

   logic [WIDX_W-1:0] num_words;
   logic [WIDX_W-1:0] word_idx;
   logic [8:0]        shift_cnt;
   logic [WW-1:0]     wait_cnt;
   logic              sample;
   logic              advance;
   logic              last_word;

   // window verdict: sample hit, or move on after a reported hit
   assign sample    = (state == EVAL) && (wait_cnt == LAT);
   assign advance   = (sample && !hit) || (state == STOP);
   assign last_word = (word_idx == num_words - I_ONE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and datapath strobes
   always_comb begin
      state_nxt     = state;
      queryInReady  = 1'b0;
      ddrReady      = 1'b0;
      dataBaseValid = 1'b0;
      load          = 1'b0;
      shift         = 1'b0;
      stop          = 1'b0;
      hitValid      = 1'b0;
      done          = 1'b0;
      busy          = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = (numWords == '0) ? DONE : QLOAD;
         end
         QLOAD: begin
            queryInReady = 1'b1;
            if (queryInValid) state_nxt = FETCH;
         end
         FETCH: begin
            ddrReady = 1'b1;
            if (ddrValid) state_nxt = LOAD;
         end
         LOAD: begin
            load          = 1'b1;
            dataBaseValid = 1'b1;
            state_nxt     = EVAL;
         end
         EVAL: begin
            if (wait_cnt < LAT_M1)  stop          = 1'b1;
            if (wait_cnt == LAT_M1) dataBaseValid = 1'b1;
            if (sample && hit)      state_nxt     = REPORT;
         end
         SHIFT: begin
            shift     = 1'b1;
            stop      = 1'b1;
            state_nxt = EVAL;
         end
         REPORT: begin
            hitValid = 1'b1;
            if (hitReady) state_nxt = STOP;
         end
         STOP: begin
            stop = 1'b1;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (advance) begin
         if (shift_cnt < SPW) state_nxt = SHIFT;
         else if (last_word)  state_nxt = DONE;
         else                 state_nxt = FETCH;
      end
   end

   // word, shift and latency counters
   always_ff @(posedge clk) begin
      if (rst) begin
         num_words <= '0;
         word_idx  <= '0;
         shift_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (state == IDLE && start) begin
            num_words <= numWords;
            word_idx  <= '0;
         end
         if (state == LOAD || state == SHIFT)
            wait_cnt <= '0;
         else if (state == EVAL && wait_cnt != LAT)
            wait_cnt <= wait_cnt + W_ONE;
         if (state == LOAD)
            shift_cnt <= '0;
         else if (state == SHIFT)
            shift_cnt <= shift_cnt + 9'd1;
         if (advance && shift_cnt == SPW && !last_word)
            word_idx <= word_idx + I_ONE;
      end
   end

   // registered query and database word to the datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         query      <= '0;
         queryValid <= 1'b0;
         dataBase   <= '0;
      end else begin
         queryValid <= (state == QLOAD) && queryInValid;
         if (state == QLOAD && queryInValid) query <= queryIn;
         if (state == FETCH && ddrValid) dataBase <= ddrData;
      end
   end

   // hit record capture, held through REPORT
   always_ff @(posedge clk) begin
      if (rst) begin
         hitWordIdx <= '0;
         hitShift   <= '0;
         hitQLoc    <= '0;
      end else if (sample && hit) begin
         hitWordIdx <= word_idx;
         hitShift   <= shift_cnt;
         hitQLoc    <= locationQ;
      end
   end

endmodule
